ppt_pulse_sequencer: RTL

Multi-channel, parametrised successor to the single-channel PPT pulse generator. It drives NUM_CH pulse outputs from one shared period counter. Each channel has its own width and phase delay. A burst mode stops the sequence after a programmed number of periods. The block sits between the register interface and the PPT igniter/discharge drivers.

---
 rtl/ppt_pkg.sv | 8 +
 rtl/ppt_channel_cmp.sv | 21 ++
 rtl/ppt_pulse_sequencer.sv | 96 +++++++++
 3 files changed

// File: rtl/ppt_pkg.sv
// ppt_pkg: shared state type, default counter width and slice helper for the PPT pulse sequencer
package ppt_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} ppt_state_t;
   localparam int PPT_CNT_W = 16;
   function automatic int ch_lsb(input int k, input int w);
      return k * w;
   endfunction
endpackage

// File: rtl/ppt_channel_cmp.sv
// ppt_channel_cmp: per-channel window compare with registered pulse output
module ppt_channel_cmp import ppt_pkg::*; #(
   parameter int CNT_W = PPT_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] counter,
   input  logic [CNT_W-1:0] delay,
   input  logic [CNT_W-1:0] width,
   input  logic [CNT_W-1:0] period,
   input  logic             en,
   input  logic             allow,
   output logic             act,
   output logic             pulse
);
   // widened sum so delay+width never wraps back into the window
   assign act = counter >= delay && {1'b0, counter} < {1'b0, delay} + {1'b0, width} && counter <= period;
   always_ff @(posedge clk)
      if (rst) pulse <= 1'b0;
      else pulse <= en && act && allow;
endmodule

// File: rtl/ppt_pulse_sequencer.sv
// ppt_pulse_sequencer: multi-channel PPT pulse sequencer with shared period counter and burst mode.
// Define PPT_OVERLAP_LOCKOUT_EN to let only the lowest-index active channel drive in any cycle.
module ppt_pulse_sequencer import ppt_pkg::*; #(
   parameter int CNT_W  = PPT_CNT_W,
   parameter int NUM_CH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    run,
   input  logic [CNT_W-1:0]        period,
   input  logic [NUM_CH*CNT_W-1:0] width,
   input  logic [NUM_CH*CNT_W-1:0] delay,
   input  logic [CNT_W-1:0]        burst,
   output logic [NUM_CH-1:0]       pulse_out,
   output logic                    busy,
   output logic                    done,
   output logic [CNT_W-1:0]        periods
);
   ppt_state_t state, nxt;
   logic [CNT_W-1:0] counter, period_r, burst_r;
   logic [NUM_CH*CNT_W-1:0] width_r, delay_r;
   logic armed, wrap, last, stay;
   logic [NUM_CH-1:0] act, allow;

   assign wrap = counter == period_r;
   assign last = burst_r != '0 && {1'b0, periods} + (CNT_W+1)'(1) == {1'b0, burst_r};
   assign stay = state == ST_RUN && nxt == ST_RUN;

   // abort (run low) outranks the final wrap
   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE: nxt = run && armed ? ST_RUN : ST_IDLE;
         ST_RUN:  nxt = !run ? ST_IDLE : (wrap && last ? ST_DONE : ST_RUN);
         ST_DONE: nxt = run ? ST_DONE : ST_IDLE;
         default: nxt = ST_IDLE;
      endcase
   end

`ifdef PPT_OVERLAP_LOCKOUT_EN
   logic seen;
   always_comb begin
      seen = 1'b0;
      allow = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         allow[k] = !seen;
         seen = seen | act[k];
      end
   end
`else
   assign allow = '1;
`endif

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      ppt_channel_cmp #(.CNT_W(CNT_W)) u_cmp (
         .clk    (clk),
         .rst    (rst),
         .counter(counter),
         .delay  (delay_r[ch_lsb(k, CNT_W) +: CNT_W]),
         .width  (width_r[ch_lsb(k, CNT_W) +: CNT_W]),
         .period (period_r),
         .en     (stay),
         .allow  (allow[k]),
         .act    (act[k]),
         .pulse  (pulse_out[k])
      );
   end

   always_ff @(posedge clk)
      if (rst) begin
         state    <= ST_IDLE;
         counter  <= '0;
         periods  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         armed    <= 1'b1;
         period_r <= '0;
         burst_r  <= '0;
         width_r  <= '0;
         delay_r  <= '0;
      end else begin
         state   <= nxt;
         busy    <= nxt == ST_RUN;
         done    <= state == ST_RUN && nxt == ST_DONE;
         armed   <= !run ? 1'b1 : (nxt == ST_DONE ? 1'b0 : armed);
         counter <= stay ? (wrap ? '0 : counter + 1'b1) : '0;
         if (state == ST_IDLE) begin
            period_r <= period;
            burst_r  <= burst;
            width_r  <= width;
            delay_r  <= delay;
         end
         if (state == ST_IDLE && nxt == ST_RUN) periods <= '0;
         else if (state == ST_RUN && nxt != ST_IDLE && wrap && periods != '1) periods <= periods + 1'b1;
      end
endmodule
